// File: rtl/time_disp_pkg.sv
// Shared constants for the multiplexed time display: field slices of the
// packed time word, setting-field select codes and active-low 7-segment
// patterns ({g,f,e,d,c,b,a}). Also holds the binary-to-BCD helpers.
package time_disp_pkg;

    localparam int HOUR_MSB   = 20;
    localparam int HOUR_LSB   = 14;
    localparam int MIN_MSB    = 13;
    localparam int MIN_LSB    = 7;
    localparam int SEC_MSB    = 6;
    localparam int SEC_LSB    = 0;
    localparam int NUM_DIGITS = 6;

    localparam logic [1:0] SEL_HOUR = 2'b00;
    localparam logic [1:0] SEL_MIN  = 2'b01;
    localparam logic [1:0] SEL_NONE = 2'b10;
    localparam logic [1:0] SEL_SEC  = 2'b11;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    // BCD code reserved for "field out of range" dashes
    localparam logic [3:0] BCD_DASH = 4'hF;

    function automatic logic [3:0] bcd_tens(input logic [6:0] v);
        logic [6:0] q;
        q = v / 7'd10;
        return q[3:0];
    endfunction

    function automatic logic [3:0] bcd_units(input logic [6:0] v);
        logic [6:0] r;
        r = v % 7'd10;
        return r[3:0];
    endfunction

endpackage

// File: rtl/time_display_scan_seg7_decode.sv
// Combinational BCD to active-low 7-segment decoder; code 4'hF shows a dash,
// other non-decimal codes show nothing.
module seg7_decode
    import time_disp_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Pattern lookup for one digit
    always_comb begin
        o_seg = SEG_OFF;
        case (i_bcd)
            4'd0:     o_seg = SEG_0;
            4'd1:     o_seg = SEG_1;
            4'd2:     o_seg = SEG_2;
            4'd3:     o_seg = SEG_3;
            4'd4:     o_seg = SEG_4;
            4'd5:     o_seg = SEG_5;
            4'd6:     o_seg = SEG_6;
            4'd7:     o_seg = SEG_7;
            4'd8:     o_seg = SEG_8;
            4'd9:     o_seg = SEG_9;
            BCD_DASH: o_seg = SEG_DASH;
            default:  o_seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/time_display_scan.sv
// Six-digit multiplexed time display driver. Snapshots the packed time word
// at each frame start, scans digits 0..5 (seconds units .. hours tens) with a
// one-cycle all-off gap at every slot change to avoid ghosting.
// Optional blink of the field being set: define TIME_DISPLAY_BLINK_EN.
module time_display_scan
    import time_disp_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [20:0] t,
    input  logic        enSet,
    input  logic [1:0]  select,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [5:0]  an
);

    localparam int         PW       = $clog2(SCAN_DIV);
    localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

    logic [PW-1:0] r_presc;
    logic [2:0]    r_idx;
    logic          r_first;
    logic          r_show;
    logic [20:0]   r_snap;
    logic [6:0]    r_seg;
    logic          r_dp;
    logic [5:0]    r_an;

    logic          w_tick;
    logic [6:0]    w_val;
    logic [3:0]    w_bcd;
    logic [6:0]    w_seg;
    logic          w_blank;

    assign w_tick = (r_presc == PW'(SCAN_DIV - 1));

    // Field value of the digit currently selected, taken from the snapshot
    always_comb begin
        case (r_idx[2:1])
            2'd0:    w_val = r_snap[SEC_MSB:SEC_LSB];
            2'd1:    w_val = r_snap[MIN_MSB:MIN_LSB];
            default: w_val = r_snap[HOUR_MSB:HOUR_LSB];
        endcase
    end

    assign w_bcd = (w_val > 7'd99) ? BCD_DASH
                 : (r_idx[0] ? bcd_tens(w_val) : bcd_units(w_val));

    seg7_decode u_dec (
        .i_bcd (w_bcd),
        .o_seg (w_seg)
    );

`ifdef TIME_DISPLAY_BLINK_EN
    localparam int BW = $clog2(BLINK_DIV + 1);

    logic [BW-1:0] r_frame;
    logic          r_phase;
    logic          w_frame_start;

    assign w_frame_start = w_tick && (r_first || r_idx == LAST_IDX);

    // Frame counter and blink phase, toggled every BLINK_DIV frames
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frame <= '0;
            r_phase <= 1'b0;
        end else if (w_frame_start) begin
            if (r_frame == BW'(BLINK_DIV - 1)) begin
                r_frame <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_frame <= r_frame + 1'b1;
            end
        end
    end

    assign w_blank = enSet && r_phase &&
                     ((select == SEL_SEC  && r_idx[2:1] == 2'd0) ||
                      (select == SEL_MIN  && r_idx[2:1] == 2'd1) ||
                      (select == SEL_HOUR && r_idx[2:1] == 2'd2));
`else
    localparam int unused_blink_div = BLINK_DIV;
    logic w_unused_set;
    assign w_unused_set = ^{enSet, select};
    assign w_blank      = 1'b0;
`endif

    // Prescaler, digit index, snapshot and registered digit outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= '0;
            r_first <= 1'b1;
            r_show  <= 1'b0;
            r_snap  <= '0;
            r_an    <= 6'b111111;
            r_seg   <= SEG_OFF;
            r_dp    <= 1'b1;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            r_show  <= w_tick;
            if (w_tick) begin
                r_first <= 1'b0;
                // The first slot after reset is digit 0, not digit 1
                if (r_first || r_idx == LAST_IDX) begin
                    r_idx  <= '0;
                    r_snap <= t;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
                r_an  <= 6'b111111;
                r_seg <= SEG_OFF;
                r_dp  <= 1'b1;
            end else if (r_show) begin
                r_an  <= w_blank ? 6'b111111 : ~(6'b000001 << r_idx);
                r_seg <= w_seg;
                r_dp  <= ~(r_idx == 3'd2 || r_idx == 3'd4);
            end
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule
